// File: rtl/adder_pkg.sv
// Shared constants and op encoding for the packed SIMD adder.
// Optional saturation is enabled by defining ADDER_SAT_EN.
package adder_pkg;

    localparam int LEN_DATA_DEF = 64;
    localparam int LANE_W_DEF   = 8;
    localparam int STAGES_DEF   = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int lanes(input int len_data, input int lane_w);
        return len_data / lane_w;
    endfunction

endpackage

// File: rtl/adder_simd_pipe_if.sv
// Operand/result bundle of the SIMD adder.
// The sat request exists only when ADDER_SAT_EN is defined.
interface adder_simd_pipe_if
    import adder_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF,
    parameter int LANE_W   = LANE_W_DEF
);
    localparam int LANES = lanes(LEN_DATA, LANE_W);

    logic                en;
    logic                valid;
    logic [LEN_DATA-1:0] a;
    logic [LEN_DATA-1:0] b;
    logic                cin;
    logic                sub;
    logic [LANES-1:0]    cmsk_n;
`ifdef ADDER_SAT_EN
    logic                sat;
`endif
    logic [LEN_DATA-1:0] sum;
    logic                cout;
    logic [LANES-1:0]    lane_cout;
    logic                rdy;

    modport master (
        output en, valid, a, b, cin, sub, cmsk_n,
`ifdef ADDER_SAT_EN
        output sat,
`endif
        input  sum, cout, lane_cout, rdy
    );

    modport slave (
        input  en, valid, a, b, cin, sub, cmsk_n,
`ifdef ADDER_SAT_EN
        input  sat,
`endif
        output sum, cout, lane_cout, rdy
    );

endinterface

// File: rtl/adder_lane.sv
// One LANE_W-bit ripple slice; segment carry muxing lives in the top.
module adder_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_simd_pipe.sv
// Pipelined SIMD add/sub: lane groups of LANES/STAGES per stage.
// Define ADDER_SAT_EN to add per-segment saturation in the last stage.
module adder_simd_pipe
    import adder_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int STAGES   = STAGES_DEF
) (
    input logic              clk,
    input logic              rst,
    adder_simd_pipe_if.slave bus
);
    localparam int LANES = lanes(LEN_DATA, LANE_W);
    localparam int L     = LANES / STAGES;

    logic [STAGES-1:0]   v_q;
    logic [LEN_DATA-1:0] a_q   [STAGES];
    logic [LEN_DATA-1:0] b_q   [STAGES];
    logic [LEN_DATA-1:0] s_q   [STAGES];
    logic [LANES-1:0]    lc_q  [STAGES];
    logic [LANES-1:0]    msk_q [STAGES];
    logic [STAGES-1:0]   c_q;
    logic [STAGES-1:0]   sub_q;
    logic [STAGES-1:0]   cin_q;
`ifdef ADDER_SAT_EN
    logic [STAGES-1:0]   sat_q;
`endif

    logic [LEN_DATA-1:0] s_d  [STAGES];
    logic [LANES-1:0]    lc_d [STAGES];
    logic [LANE_W-1:0]   ls   [LANES];
    logic [LANES-1:0]    lco;
    logic [LEN_DATA-1:0] fin_sum;

    logic                rdy_q;
    logic [LEN_DATA-1:0] sum_q;
    logic                cout_q;
    logic [LANES-1:0]    lcout_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int G = i / L;
        logic              seg_ci;
        logic              ci;
        logic              co;
        logic [LANE_W-1:0] s;

        assign seg_ci = cin_q[G] ^ (op_e'(sub_q[G]) == OP_SUB);

        if (i == 0) begin : g_first
            assign ci = seg_ci;
        end else if (i % L == 0) begin : g_grp
            assign ci = msk_q[G][i] ? c_q[G] : seg_ci;
        end else begin : g_mid
            assign ci = msk_q[G][i] ? g_lane[i-1].co : seg_ci;
        end

        adder_lane #(.W(LANE_W)) u_lane (
            .a  (a_q[G][i*LANE_W +: LANE_W]),
            .b  (b_q[G][i*LANE_W +: LANE_W] ^ {LANE_W{sub_q[G]}}),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        assign ls[i]  = s;
        assign lco[i] = co;
    end

    // Merge each stage's freshly summed lane group into its partial result
    always_comb begin
        for (int g = 0; g < STAGES; g++) begin
            s_d[g]  = s_q[g];
            lc_d[g] = lc_q[g];
        end
        for (int i = 0; i < LANES; i++) begin
            s_d[i/L][i*LANE_W +: LANE_W] = ls[i];
            lc_d[i/L][i]                 = lco[i];
        end
    end

`ifdef ADDER_SAT_EN
    logic [LANES-1:0] seg_end;
    assign seg_end = {1'b1, ~msk_q[STAGES-1][LANES-1:1]};

    // Clamp saturating segments using the carry out of their top lane
    always_comb begin
        logic segc;
        logic sb;
        fin_sum = s_d[STAGES-1];
        segc    = 1'b0;
        sb      = sub_q[STAGES-1];
        for (int i = LANES - 1; i >= 0; i--) begin
            if (seg_end[i]) segc = lc_d[STAGES-1][i];
            if (sat_q[STAGES-1]) begin
                if (sb && !segc)
                    fin_sum[i*LANE_W +: LANE_W] = '0;
                else if (!sb && segc)
                    fin_sum[i*LANE_W +: LANE_W] = '1;
            end
        end
    end
`else
    assign fin_sum = s_d[STAGES-1];
`endif

    // Stage valid bits; reset flushes in-flight operations
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else if (bus.en) begin
            v_q[0] <= bus.valid;
            for (int k = 1; k < STAGES; k++) v_q[k] <= v_q[k-1];
        end
    end

    // Operand, partial-sum and control pipeline, qualified by v_q
    always_ff @(posedge clk) begin
        if (bus.en) begin
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.b;
            s_q[0]   <= '0;
            lc_q[0]  <= '0;
            msk_q[0] <= bus.cmsk_n;
            c_q[0]   <= 1'b0;
            sub_q[0] <= bus.sub;
            cin_q[0] <= bus.cin;
`ifdef ADDER_SAT_EN
            sat_q[0] <= bus.sat;
`endif
            for (int k = 1; k < STAGES; k++) begin
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                s_q[k]   <= s_d[k-1];
                lc_q[k]  <= lc_d[k-1];
                msk_q[k] <= msk_q[k-1];
                c_q[k]   <= lco[k*L-1];
                sub_q[k] <= sub_q[k-1];
                cin_q[k] <= cin_q[k-1];
`ifdef ADDER_SAT_EN
                sat_q[k] <= sat_q[k-1];
`endif
            end
        end
    end

    // Result registers load only from a valid final stage
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            lcout_q <= '0;
        end else if (bus.en) begin
            rdy_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                sum_q   <= fin_sum;
                cout_q  <= lco[LANES-1];
                lcout_q <= lc_d[STAGES-1];
            end
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.lane_cout = lcout_q;

endmodule

// File: tb/tb_adder_simd_pipe.sv
// Scoreboard bench for adder_simd_pipe with a segment-level reference model.
// Saturation cases are exercised when ADDER_SAT_EN is defined.
module tb_adder_simd_pipe;
    import adder_pkg::*;

    localparam int LD = 64;
    localparam int W  = 8;
    localparam int S  = 4;
    localparam int N  = LD / W;

    typedef struct packed {
        logic [LD-1:0] sum;
        logic          cout;
        logic [N-1:0]  lc;
        logic [31:0]   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_simd_pipe_if #(.LEN_DATA(LD), .LANE_W(W)) bus ();

    adder_simd_pipe #(.LEN_DATA(LD), .LANE_W(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    int   pops   = 0;
    exp_t q[$];

    // Reference: each segment is one wide integer add; lane carries are
    // the bits just above each lane of the running segment sum.
    function automatic exp_t model(input logic [LD-1:0] a, input logic [LD-1:0] b,
                                   input logic cin, input logic sub,
                                   input logic [N-1:0] msk, input logic sat);
        exp_t       e;
        logic [71:0] bx, t, m;
        logic [N:0]  mx;
        int          st;
        e  = '0;
        bx = {8'b0, (sub ? ~b : b)};
        st = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 0 || !msk[i]) st = i;
            m = (72'd1 << ((i - st + 1) * W)) - 72'd1;
            t = (({8'b0, a} >> (st * W)) & m) + ((bx >> (st * W)) & m)
                + {71'b0, cin ^ sub};
            e.lc[i]          = t[(i - st + 1) * W];
            e.sum[i*W +: W]  = t[(i - st) * W +: W];
        end
        e.cout = e.lc[N-1];
        if (sat) begin
            mx = {1'b0, msk};
            st = 0;
            for (int i = 0; i < N; i++) begin
                if (i == 0 || !msk[i]) st = i;
                if (i == N - 1 || !mx[i+1]) begin
                    for (int j = st; j <= i; j++) begin
                        if (!sub && e.lc[i]) e.sum[j*W +: W] = '1;
                        if (sub && !e.lc[i]) e.sum[j*W +: W] = '0;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        if (bus.en && !rst) edges++;
        #1;
    endtask

    task automatic issue(input logic [LD-1:0] a, input logic [LD-1:0] b,
                         input logic cin, input logic sub,
                         input logic [N-1:0] msk, input logic sat);
        exp_t e;
        logic acc;
        logic sat_eff;
        bus.valid  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        bus.sub    = sub;
        bus.cmsk_n = msk;
`ifdef ADDER_SAT_EN
        bus.sat    = sat;
        sat_eff    = sat;
`else
        sat_eff    = 1'b0;
`endif
        acc = bus.en && !rst;
        step();
        if (acc) begin
            e     = model(a, b, cin, sub, msk, sat_eff);
            e.acc = edges;
            q.push_back(e);
        end
    endtask

    task automatic rnd_issue();
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
              1'($urandom), N'($urandom), 1'($urandom));
    endtask

    task automatic bubble(input int n);
        bus.valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        bus.valid = 1'b0;
        bus.en    = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [LD-1:0] got,
                       input logic [LD-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    logic          p_en = 1'b1;
    logic          p_rst = 1'b1;
    logic          p_ok = 1'b0;
    logic          p_rdy;
    logic [LD-1:0] p_sum;
    logic          p_cout;
    logic [N-1:0]  p_lc;

    // Monitor: freeze check across disabled edges, then scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (p_ok && !p_en && !p_rst) begin
            chk("freeze_rdy", LD'(bus.rdy), LD'(p_rdy));
            chk("freeze_sum", bus.sum, p_sum);
            chk("freeze_cout", LD'(bus.cout), LD'(p_cout));
            chk("freeze_lane_cout", LD'(bus.lane_cout), LD'(p_lc));
        end
        if (!rst && bus.en && bus.rdy) begin
            pops++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: rdy=1 with no pending op, required none");
            end else begin
                e = q.pop_front();
                chk("sum", bus.sum, e.sum);
                chk("cout", LD'(bus.cout), LD'(e.cout));
                chk("lane_cout", LD'(bus.lane_cout), LD'(e.lc));
                chk("latency", LD'(edges - int'(e.acc)), LD'(S));
            end
        end
        p_ok   = 1'b1;
        p_en   = bus.en;
        p_rst  = rst;
        p_rdy  = bus.rdy;
        p_sum  = bus.sum;
        p_cout = bus.cout;
        p_lc   = bus.lane_cout;
    end

    initial begin
        int base;
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.valid  = 1'b1;
        bus.a      = {$urandom, $urandom};
        bus.b      = {$urandom, $urandom};
        bus.cin    = 1'b1;
        bus.sub    = 1'b0;
        bus.cmsk_n = '1;
`ifdef ADDER_SAT_EN
        bus.sat    = 1'b0;
`endif
        step();
        chk("reset_rdy", LD'(bus.rdy), '0);
        chk("reset_sum", bus.sum, '0);
        chk("reset_cout", LD'(bus.cout), '0);
        chk("reset_lane_cout", LD'(bus.lane_cout), '0);
        bus.a = {$urandom, $urandom};
        step();
        step();
        rst = 1'b0;

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 8'hFF, 1'b0);
        issue(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001,
              1'b0, 1'b0, 8'h00, 1'b0);
        issue(64'd5, 64'd7, 1'b0, 1'b1, 8'hFF, 1'b0);
        drain();

        base = pops;
        for (int i = 0; i < 16; i++) begin
            rnd_issue();
            if (i == 5) begin
                bus.en = 1'b0;
                repeat (3) rnd_issue();
                bus.en = 1'b1;
            end
            if (i == 9) bubble(2);
        end
        drain();
        chk("stream_rdy_count", LD'(pops - base), LD'(16));

        rnd_issue();
        rnd_issue();
        rst = 1'b1;
        step();
        q.delete();
        rst = 1'b0;
        rnd_issue();
        drain();

`ifdef ADDER_SAT_EN
        issue({8{8'hF0}}, {8{8'h20}}, 1'b0, 1'b0, 8'h00, 1'b1);
        issue({8{8'h10}}, {8{8'h20}}, 1'b0, 1'b1, 8'h00, 1'b1);
        drain();
`endif

        for (int i = 0; i < 60; i++) begin
            bus.en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) bubble(1);
            else rnd_issue();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_simd_pipe.md
# adder_simd_pipe

Parametrised, pipelined SIMD adder/subtractor; successor to the fixed 64-bit `adder64`. It splits a `LEN_DATA`-wide operand pair into `LANE_W`-bit lanes. A per-lane carry mask groups those lanes into independent segments. The carry chain is spread over `STAGES` register stages, giving one result per clock at full rate. It sits in the execute datapath as the integer/packed add unit, behind the operand read stage.

## Interface
Parameters:
- `LEN_DATA`, 64 – operand width.
- `LANE_W`, 8 – lane width. `LANES = LEN_DATA/LANE_W`. `LEN_DATA % LANE_W == 0` is required.
- `STAGES`, 4 – pipeline depth, ≥1. `LANES % STAGES == 0` is required.

Ports:
- `clk` in 1 – clock. One clock domain, all logic on the rising edge.
- `rst` in 1 – reset, **synchronous, active-high**.
- `en` in 1 – pipeline enable. When 0 the entire pipeline freezes.
- `valid` in 1 – operands present this cycle.
- `a`, `b` in `LEN_DATA` – operands.
- `cin` in 1 – segment carry-in (add) or borrow-in (sub).
- `sub` in 1 – 0 gives a+b+cin; 1 gives a−b−cin.
- `cmsk_n` in `LANES` – bit i=1 chains the carry from lane i−1 into lane i; 0 starts a new segment at lane i. Bit 0 is ignored, because lane 0 always starts a segment.
- `sat` in 1 – saturate request. Exists only under `ADDER_SAT_EN`.
- `sum` out `LEN_DATA` – result.
- `cout` out 1 – raw carry out of lane `LANES-1`.
- `lane_cout` out `LANES` – raw carry out of each lane.
- `rdy` out 1 – result valid. High for exactly one `en`-cycle per accepted operation.

## Operation
- Accept rule: an operation is accepted on a rising edge with `en=1 && valid=1 && rst=0`.
- Subtract mode: `b` is inverted and the segment carry-in is `~cin`. Lane carry-outs are therefore not-borrow.
- Segment carry-in: every segment-start lane receives the segment carry-in. Every other lane receives the carry-out of lane i−1.
- Stage k (k=0..STAGES−1) computes lanes `[k·L, (k+1)·L−1]`, where `L=LANES/STAGES`.
- Data carried between stages:
  - the carry into the next lane group;
  - the lanes already summed;
  - the remaining operands;
  - the control bits `sub`, `cin`, `cmsk_n` and `sat`.
- Each stage holds a valid bit. On `en=1`, `valid=0` inserts a bubble.
- `sum`, `cout` and `lane_cout` update only when the final stage holds a valid operation, and hold their value otherwise.
- Operations complete strictly in order. None are dropped or duplicated.

## Timing
- Latency is `STAGES` enabled cycles. An operation accepted at edge n gives `rdy=1` and its result after edge n+STAGES, when `en` stayed 1 throughout.
- Throughput is one operation per cycle.
- `en=0`: no register changes, including the stage valid bits. `rdy` holds its current value, and the operation shown is not re-consumed when `en` returns.
- `rst=1` has priority over `en`. After that edge:
  - all stage valid bits are 0;
  - `rdy=0`, `sum=0`, `cout=0`, `lane_cout=0`.
- Reset during operation: in-flight operations are discarded. The first operation accepted after reset completes `STAGES` cycles after acceptance.
- `STAGES=1`: a plain registered adder with latency 1.
- Wrap-around: unsaturated results are modulo 2^(segment width). Carry beyond lane `LANES-1` is reported only on `cout`.

## Configuration
- Macro: `ADDER_SAT_EN`.
- Defined:
  - the `sat` port exists;
  - in the final stage, each segment with `sat=1` is fixed up using the carry-out of its last lane;
  - in add mode, carry=1 forces every bit of the segment to 1;
  - in sub mode, carry=0 (a borrow) forces the segment to 0;
  - `cout` and `lane_cout` stay raw;
  - latency is unchanged.
- Undefined: there is no `sat` port and no saturation logic. Results always wrap.

## Structure
- Shared package `adder_pkg`:
  - the default `LEN_DATA`/`LANE_W`/`STAGES`;
  - a `lanes()` constant function;
  - the op encoding (`OP_ADD=0`, `OP_SUB=1`).
- One sub-module, `adder_lane`: a `LANE_W`-bit slice.
  - Inputs: `a`, `b`, `ci`.
  - Outputs: `s`, `co`.
  - It is generated `LANES` times across the stages. Segment muxing of the carry stays in the top module.

## Test plan
Tests use default parameters (LANES=8, STAGES=4).
- **Reset:** `rst=1` for 3 cycles with `valid=1` and random operands → `rdy=0`, `sum=0`, `cout=0`, `lane_cout=0` after the first reset edge.
- **Full-width carry:** `a=64'hFFFF_FFFF_FFFF_FFFF`, `b=1`, `cin=0`, `cmsk_n=8'hFF` → exactly 4 cycles later:
  - `rdy=1`;
  - `sum=0`;
  - `cout=1`;
  - `lane_cout=8'hFF`.
- **Segmented:** `cmsk_n=8'h00`, `a=64'h00FF_00FF_00FF_00FF`, `b=64'h0001_0001_0001_0001` → `sum=0`, `lane_cout=8'h55`, `cout=0`.
- **Subtract:** `sub=1`, `cin=0`, `cmsk_n=8'hFF`, `a=5`, `b=7` → `sum=64'hFFFF_FFFF_FFFF_FFFE`, `cout=0`.
- **Streaming and stalls:**
  - drive 16 back-to-back random operations with mixed `sub`, `cin` and `cmsk_n`;
  - drop `en` for 3 cycles after the 6th operation, and insert 2 bubbles;
  - required: results in order and equal to the reference model, with `rdy` count=16 and outputs frozen during `en=0`.
- **Saturation (`ADDER_SAT_EN`):** `sat=1`, `cmsk_n=8'h00`.
  - Add: each lane `a=8'hF0`, `b=8'h20` → every lane `8'hFF`.
  - Sub: each lane `a=8'h10`, `b=8'h20` → every lane `8'h00`.
